pwm_ramp_controller: RTL
========================

// Module: pwm_ramp_controller
// PURPOSE
//  Sequencer in front of the 10-step PWM generator; drives its increase_duty/decrease_duty inputs.
//  Accepts a target duty via valid/ready and walks the generator's duty one step every
//  STEP_CYCLES clocks until the target is reached (soft-start / soft-change).
//  Keeps a shadow copy of the generator's duty, since the generator exposes no duty readback.
// PARAMETERS
//  DUTY_MAX    9   highest legal duty step (generator range 0..DUTY_MAX)
//  DUTY_RESET  5   generator power-up duty; shadow reset value
//  STEP_CYCLES 16  clocks between successive step pulses; legal range 2..65535
//  DW          4   duty width in bits
// PORTS
//  clk            in   1   single clock, shared with the PWM generator
//  rst            in   1   synchronous, active-high reset
//  tgt_valid      in   1   target duty request valid
//  tgt_ready      out  1   high only in IDLE
//  tgt_duty       in   DW  requested duty step
//  abort          in   1   stop the ramp in progress
//  increase_duty  out  1   1-cycle step-up pulse to the generator
//  decrease_duty  out  1   1-cycle step-down pulse to the generator
//  duty_track     out  DW  shadow of the generator duty
//  busy           out  1   high in RAMP_UP or RAMP_DOWN
//  done           out  1   1-cycle pulse when the target is reached
//  err_range      out  1   1-cycle pulse when tgt_duty > DUTY_MAX
// BEHAVIOUR
//  - States: IDLE, RAMP_UP, RAMP_DOWN. All outputs are registered.
//  - Reset values: state=IDLE, duty_track=DUTY_RESET, timer=0, tgt_ready=1, all pulses/busy=0.
//  - Accept: the edge where tgt_valid && tgt_ready. tgt_duty > DUTY_MAX is clamped to DUTY_MAX,
//    err_range pulses the next cycle, and the request is still accepted.
//  - Accepted target == duty_track: done pulses the next cycle, no step pulses, stay in IDLE.
//  - Target > duty_track: go to RAMP_UP. Target < duty_track: go to RAMP_DOWN.
//    In both cases timer loads STEP_CYCLES-1.
//  - RAMP: timer decrements every cycle. On the edge where timer==0:
//      - register one pulse (increase or decrease) and update duty_track by +/-1 on that same edge;
//      - reload the timer.
//    First pulse appears STEP_CYCLES cycles after the accept edge; total |delta|*STEP_CYCLES.
//  - Final step: the edge that makes duty_track == target also registers done=1 and returns to IDLE.
//    tgt_ready=1 in the same cycle as the last pulse and done.
//  - duty_track leads the generator's internal duty by 1 cycle (generator samples the pulse next edge).
//  - Pulse spacing: increase and decrease are never high together, and never high in consecutive cycles.
//  - abort in RAMP: IDLE next edge, timer cleared, duty_track holds, no done.
//    abort on a timer==0 cycle wins, so no pulse is issued. abort in IDLE is ignored.
//  - tgt_valid while busy: not accepted; the requester holds tgt_duty stable until ready.
//  - rst mid-ramp: immediate return to reset values; any pulse in flight is dropped.
//    System rule: rst is asserted only together with generator initialisation, so duty_track=DUTY_RESET is valid.
//  - Arithmetic: duty_track is saturating by construction and never leaves 0..DUTY_MAX.
// CONFIGURATION
//  PWM_RAMP_MANUAL_EN defined:
//    - Adds inputs btn_up and btn_down (1-bit, synchronised externally).
//    - In IDLE, a registered rising edge on btn_up issues one increase pulse and duty_track+1,
//      only if duty_track < DUTY_MAX; btn_down likewise, only if duty_track > 0.
//    - Both edges in the same cycle: neither acts.
//    - A button edge and a tgt accept in the same cycle: the accept wins and the button is dropped.
//    - Buttons are ignored in RAMP.
//  Undefined: btn_up/btn_down ports are absent; duty changes only via the target handshake.
// TESTING (STEP_CYCLES=4 unless noted)
//  1. rst, then accept tgt 8 -> increase pulses 4/8/12 cycles after accept;
//     duty_track 6,7,8; done with the 3rd pulse.
//  2. rst, then accept tgt 5 -> done 1 cycle after accept; zero pulses; busy stays 0.
//  3. Accept tgt 12 -> err_range 1 cycle; 4 increase pulses; duty_track ends at 9; done.
//  4. From 5, tgt 0; abort 1 cycle after the 2nd decrease -> duty_track=3, no done, tgt_ready=1.
//  5. tgt_valid held high with tgt 7 during a ramp -> accepted on the cycle tgt_ready rises;
//     the ramp starts from the reached duty.
//  6. PWM_RAMP_MANUAL_EN, duty 9: btn_up edge -> no pulse.
//     At duty 5: btn_down edge -> one decrease pulse, duty_track=4.

Source files
------------

// File: rtl/pwm_ramp_controller_if.sv
// rtl/pwm_ramp_controller_if.sv - target-duty request handshake between requester and ramp controller
interface pwm_ramp_controller_if #(
    parameter int DW = 4
);
    logic          tgt_valid;
    logic          tgt_ready;
    logic [DW-1:0] tgt_duty;

    modport master (output tgt_valid, output tgt_duty, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_duty, output tgt_ready);
endinterface

// File: rtl/pwm_ramp_controller.sv
// rtl/pwm_ramp_controller.sv - soft-start duty sequencer driving the PWM generator's step inputs
// Optional manual buttons in IDLE: define PWM_RAMP_MANUAL_EN.
module pwm_ramp_controller #(
    parameter int DUTY_MAX    = 9,
    parameter int DUTY_RESET  = 5,
    parameter int STEP_CYCLES = 16,
    parameter int DW          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pwm_ramp_controller_if.slave  tgt,
    input  logic                  abort,
`ifdef PWM_RAMP_MANUAL_EN
    input  logic                  btn_up,
    input  logic                  btn_down,
`endif
    output logic                  increase_duty,
    output logic                  decrease_duty,
    output logic [DW-1:0]         duty_track,
    output logic                  busy,
    output logic                  done,
    output logic                  err_range
);
    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

    localparam logic [DW-1:0] DMAX  = DW'(DUTY_MAX);
    localparam logic [DW-1:0] DRST  = DW'(DUTY_RESET);
    localparam logic [15:0]   TLOAD = 16'(STEP_CYCLES - 1);

    state_t        state;
    logic [15:0]   timer;
    logic [DW-1:0] target;
    logic [DW-1:0] clamped;
    logic [DW-1:0] step_duty;

    always_comb begin
        clamped   = (tgt.tgt_duty > DMAX) ? DMAX : tgt.tgt_duty;
        step_duty = (state == RAMP_UP) ? duty_track + DW'(1) : duty_track - DW'(1);
    end

`ifdef PWM_RAMP_MANUAL_EN
    logic btn_up_q, btn_down_q;
    logic manual_up, manual_down;

    // A pulse in the previous cycle blocks buttons so step pulses never abut.
    always_comb begin
        manual_up   = btn_up && !btn_up_q && !(btn_down && !btn_down_q)
                      && (duty_track < DMAX) && !(increase_duty || decrease_duty);
        manual_down = btn_down && !btn_down_q && !(btn_up && !btn_up_q)
                      && (duty_track > '0) && !(increase_duty || decrease_duty);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            target        <= DRST;
            duty_track    <= DRST;
            tgt.tgt_ready <= 1'b1;
            increase_duty <= 1'b0;
            decrease_duty <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_range     <= 1'b0;
`ifdef PWM_RAMP_MANUAL_EN
            btn_up_q      <= 1'b0;
            btn_down_q    <= 1'b0;
`endif
        end else begin
            increase_duty <= 1'b0;
            decrease_duty <= 1'b0;
            done          <= 1'b0;
            err_range     <= 1'b0;
`ifdef PWM_RAMP_MANUAL_EN
            btn_up_q      <= btn_up;
            btn_down_q    <= btn_down;
`endif
            case (state)
                IDLE: begin
                    if (tgt.tgt_valid) begin
                        err_range <= (tgt.tgt_duty > DMAX);
                        target    <= clamped;
                        if (clamped == duty_track) begin
                            done <= 1'b1;
                        end else begin
                            state         <= (clamped > duty_track) ? RAMP_UP : RAMP_DOWN;
                            timer         <= TLOAD;
                            busy          <= 1'b1;
                            tgt.tgt_ready <= 1'b0;
                        end
                    end
`ifdef PWM_RAMP_MANUAL_EN
                    else if (manual_up) begin
                        increase_duty <= 1'b1;
                        duty_track    <= duty_track + DW'(1);
                    end else if (manual_down) begin
                        decrease_duty <= 1'b1;
                        duty_track    <= duty_track - DW'(1);
                    end
`endif
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (abort) begin
                        state         <= IDLE;
                        timer         <= '0;
                        busy          <= 1'b0;
                        tgt.tgt_ready <= 1'b1;
                    end else if (timer == '0) begin
                        increase_duty <= (state == RAMP_UP);
                        decrease_duty <= (state == RAMP_DOWN);
                        duty_track    <= step_duty;
                        if (step_duty == target) begin
                            state         <= IDLE;
                            timer         <= '0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            tgt.tgt_ready <= 1'b1;
                        end else begin
                            timer <= TLOAD;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    tgt.tgt_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
